// File: rtl/vga1306_fb_tx.sv
// vga1306_fb_tx: serialises SSD1306 page bytes into VGA1306
// pixel writes, MSB first, one pixel per wclk rising edge.
`timescale 1ns/1ps
module vga1306_fb_tx #(
    parameter int unsigned WCLK_DIV    = 2,
    parameter int unsigned FRAME_BYTES = 1024,
    parameter int unsigned SYNC_EDGES  = 2
) (
    input  logic       CLK25MHz,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       inverse_in,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       wclk,
    output logic       write_en,
    output logic [1:0] din,
    output logic       cs,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE, SYNC, WAIT_BYTE, SHIFT, ABORT, DONE
    } state_t;

    localparam logic [3:0]  PH_LAST = 4'(WCLK_DIV - 1);
    localparam logic [2:0]  SE_LAST = 3'(SYNC_EDGES - 1);
    localparam logic [10:0] FB_LAST = 11'(FRAME_BYTES - 1);

    state_t      st, st_n;
    logic [3:0]  ph, ph_n;
    logic [2:0]  sc, sc_n;
    logic [2:0]  bidx, bidx_n;
    logic [10:0] cnt, cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        wclk_n, we_n, pix, pix_n;
    logic        go_sync;
    logic        run, tick, fall, take;

    assign run  = (st == SYNC) || (st == SHIFT) || (st == ABORT);
    assign tick = (ph == PH_LAST);
    assign fall = run && wclk && tick;
    assign take = byte_valid && byte_ready;
    assign din  = {1'b0, pix};

    // next-state: wclk phase timing, byte shifting and frame control
    always_comb begin
        st_n    = st;
        ph_n    = ph;
        wclk_n  = wclk;
        sc_n    = sc;
        bidx_n  = bidx;
        cnt_n   = cnt;
        shreg_n = shreg;
        we_n    = write_en;
        pix_n   = pix;
        go_sync = 1'b0;
        if (run) begin
            ph_n = tick ? 4'd0 : ph + 4'd1;
            if (tick) wclk_n = ~wclk;
        end
        unique case (st)
            IDLE: go_sync = frame_start;
            SYNC: begin
                if (frame_start) begin
                    if (wclk && !tick) st_n = ABORT;
                    else go_sync = 1'b1;
                end else if (fall) begin
                    if (sc == SE_LAST) begin
                        st_n = WAIT_BYTE;
                        sc_n = 3'd0;
                    end else begin
                        sc_n = sc + 3'd1;
                    end
                end
            end
            WAIT_BYTE: begin
                if (frame_start) begin
                    go_sync = 1'b1;
                end else if (take) begin
                    st_n    = SHIFT;
                    shreg_n = byte_data;
                    bidx_n  = 3'd7;
                    pix_n   = byte_data[7];
                    we_n    = 1'b1;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    if (wclk && !tick) st_n = ABORT;
                    else go_sync = 1'b1;
                end else if (fall) begin
                    if (bidx == 3'd0) begin
                        cnt_n = cnt + 11'd1;
                        if (cnt == FB_LAST) begin
                            st_n  = DONE;
                            we_n  = 1'b0;
                            pix_n = 1'b0;
                        end else begin
                            st_n = WAIT_BYTE;
                        end
                    end else begin
                        bidx_n = bidx - 3'd1;
                        pix_n  = shreg[bidx - 3'd1];
                    end
                end
            end
            ABORT: go_sync = tick;
            DONE: begin
                if (frame_start) go_sync = 1'b1;
                else begin
                    st_n  = IDLE;
                    cnt_n = 11'd0;
                end
            end
            default: st_n = IDLE;
        endcase
        if (go_sync) begin
            st_n    = SYNC;
            ph_n    = 4'd0;
            wclk_n  = 1'b0;
            sc_n    = 3'd0;
            bidx_n  = 3'd0;
            cnt_n   = 11'd0;
            shreg_n = 8'd0;
            we_n    = 1'b0;
            pix_n   = 1'b0;
        end
    end

    // state and registered outputs
    always_ff @(posedge CLK25MHz or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            ph         <= 4'd0;
            wclk       <= 1'b0;
            sc         <= 3'd0;
            bidx       <= 3'd0;
            cnt        <= 11'd0;
            shreg      <= 8'd0;
            write_en   <= 1'b0;
            pix        <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cs         <= 1'b0;
        end else begin
            st         <= st_n;
            ph         <= ph_n;
            wclk       <= wclk_n;
            sc         <= sc_n;
            bidx       <= bidx_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            write_en   <= we_n;
            pix        <= pix_n;
            byte_ready <= (st_n == WAIT_BYTE);
            busy       <= (st_n != IDLE);
            frame_done <= (st_n == DONE);
            cs         <= inverse_in;
        end
    end

endmodule

// File: tb/tb_vga1306_fb_tx.sv
// tb_vga1306_fb_tx: byte vector table, random frames and a
// far-end pixel memory model fed by observed wclk edges.
`timescale 1ns/1ps
module tb_vga1306_fb_tx;

    localparam int WD   = 2;
    localparam int NB   = 1024;
    localparam int SE   = 2;
    localparam int NPIX = 8 * NB;

    typedef struct packed {
        logic [7:0] b;
        logic       inv;
        logic [7:0] seq;
    } vec_t;

    logic       CLK25MHz = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       inverse_in = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready, wclk, write_en, cs, busy, frame_done;
    logic [1:0] din;

    vga1306_fb_tx #(
        .WCLK_DIV(WD), .FRAME_BYTES(NB), .SYNC_EDGES(SE)
    ) dut (
        .CLK25MHz(CLK25MHz), .reset_n(reset_n),
        .frame_start(frame_start), .inverse_in(inverse_in),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .wclk(wclk),
        .write_en(write_en), .din(din), .cs(cs),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 CLK25MHz = ~CLK25MHz;

    int n_pass = 0;
    int n_chk  = 0;

    bit         mon_en = 1'b0;
    logic       p_w, p_fd;
    logic [2:0] p_dw;
    int high_len, low_len, since_rise, stable_len;
    int tviol = 0, en0_edges = 0, en1_edges = 0;
    int fe_addr = 0, fd_pulses = 0, fd_long = 0;
    logic fe_mem [NPIX];
    logic [7:0] frame_q [NB];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // far end: one pixel per rising edge, address clear when disabled
    initial begin
        forever begin
            @(negedge CLK25MHz);
            if (!mon_en) begin
                high_len = WD; low_len = WD;
                since_rise = 100; stable_len = 100;
            end else begin
                if (since_rise < 100) since_rise++;
                if ({write_en, din} != p_dw) begin
                    if (since_rise < WD) tviol++;
                    stable_len = 0;
                end else if (stable_len < 100) stable_len++;
                if (wclk && !p_w) begin
                    if (low_len < WD) tviol++;
                    if (stable_len < WD) tviol++;
                    if (din[1]) tviol++;
                    if (write_en) begin
                        if (fe_addr < NPIX) fe_mem[fe_addr] = din[0];
                        fe_addr++;
                        en1_edges++;
                    end else begin
                        fe_addr = 0;
                        en0_edges++;
                    end
                    high_len = 1;
                    since_rise = 0;
                end else if (!wclk && p_w) begin
                    if (high_len != WD) tviol++;
                    low_len = 1;
                end else if (wclk) high_len++;
                else low_len++;
                if (frame_done && !p_fd) fd_pulses++;
                if (frame_done && p_fd) fd_long++;
            end
            p_w = wclk; p_dw = {write_en, din}; p_fd = frame_done;
        end
    end

    function automatic int mem_mismatch(input int nbytes);
        int m;
        logic [7:0] b;
        m = 0;
        for (int a = 0; a < 8 * nbytes; a++) begin
            b = frame_q[a / 8];
            if (fe_mem[a] !== b[7 - (a % 8)]) m++;
        end
        return m;
    endfunction

    task automatic wait_ready(input int lim);
        int c;
        c = 0;
        while (!byte_ready && c < lim) begin
            @(negedge CLK25MHz);
            c++;
        end
        chk("ready_wait", byte_ready, 1);
    endtask

    task automatic feed(input int lo, input int hi, input bit rnd);
        int idx, guard;
        idx = lo; guard = 0;
        while (idx < hi && guard < 60000) begin
            @(negedge CLK25MHz);
            guard++;
            byte_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            byte_data  = frame_q[idx];
            if (byte_valid && byte_ready) idx++;
        end
        @(negedge CLK25MHz);
        byte_valid = 1'b0;
        chk("feed_count", idx, hi);
    endtask

    task automatic pulse_start();
        @(negedge CLK25MHz);
        frame_start = 1'b1;
        @(negedge CLK25MHz);
        frame_start = 1'b0;
    endtask

    initial begin
        vec_t vt [6];
        int k, rise_k, bad, e0, e1, fd0;
        logic [7:0] seq;

        vt[0] = '{8'hA5, 1'b0, 8'hA5};
        vt[1] = '{8'h01, 1'b1, 8'h80};
        vt[2] = '{8'h80, 1'b0, 8'h01};
        vt[3] = '{8'h3C, 1'b1, 8'h3C};
        vt[4] = '{8'h0F, 1'b0, 8'hF0};
        vt[5] = '{8'hC2, 1'b1, 8'h43};

        inverse_in = 1'b1;
        repeat (3) @(negedge CLK25MHz);
        chk("rst_wclk", wclk, 0);
        chk("rst_we", write_en, 0);
        chk("rst_din", din, 0);
        chk("rst_cs", cs, 0);
        chk("rst_flags", {byte_ready, busy, frame_done}, 0);
        reset_n = 1'b1;
        inverse_in = 1'b0;
        @(negedge CLK25MHz);
        mon_en = 1'b1;

        // sync: edges with write_en=0, then byte_ready
        e0 = en0_edges;
        @(negedge CLK25MHz);
        frame_start = 1'b1;
        @(negedge CLK25MHz);
        frame_start = 1'b0;
        chk("sync_busy", busy, 1);
        k = 1;
        while (!byte_ready && k < 100) begin
            @(negedge CLK25MHz);
            k++;
        end
        chk("sync_lat", k, 1 + 2 * SE * WD);
        chk("sync_edges", en0_edges - e0, SE);
        chk("sync_we", write_en, 0);

        // vector table: bit order, latency, ready low time, cs
        for (int i = 0; i < 6; i++) begin
            wait_ready(200);
            byte_valid = 1'b1;
            byte_data  = vt[i].b;
            inverse_in = vt[i].inv;
            @(negedge CLK25MHz);
            byte_valid = 1'b0;
            chk("first_lat", {wclk, write_en, din},
                {2'b01, 1'b0, vt[i].b[7]});
            k = 1; rise_k = 0;
            while (!byte_ready && k < 200) begin
                if (wclk && rise_k == 0) rise_k = k;
                @(negedge CLK25MHz);
                k++;
            end
            chk("ready_low", k - 1, 16 * WD);
            chk("first_rise", rise_k, 1 + WD);
            for (int j = 0; j < 8; j++) seq[j] = fe_mem[8 * i + j];
            chk("pix_seq", seq, vt[i].seq);
            chk("cs_vec", cs, vt[i].inv);
            chk("wait_we", write_en, 1);
        end

        // full random frame, valid high, one 50-cycle gap
        for (int i = 0; i < NB; i++) frame_q[i] = 8'($urandom);
        e0 = en0_edges; e1 = en1_edges; fd0 = fd_pulses;
        pulse_start();
        chk("fr_nodone", fd_pulses, fd0);
        wait_ready(200);
        chk("fr_sync", en0_edges - e0, SE);
        feed(0, 500, 1'b0);
        wait_ready(200);
        k = en1_edges; bad = 0;
        repeat (50) begin
            @(negedge CLK25MHz);
            if (wclk || !write_en || !byte_ready) bad++;
        end
        chk("gap_edges", en1_edges - k, 0);
        chk("gap_state", bad, 0);
        feed(500, NB, 1'b0);
        k = 0;
        while (!frame_done && k < 200) begin
            @(negedge CLK25MHz);
            k++;
        end
        chk("done_seen", frame_done, 1);
        @(negedge CLK25MHz);
        chk("done_after", {frame_done, write_en, busy}, 0);
        chk("fr_edges", en1_edges - e1, NPIX);
        chk("fr_addr", fe_addr, NPIX);
        chk("fr_order", mem_mismatch(NB), 0);
        chk("fr_pulses", fd_pulses - fd0, 1);
        k = en0_edges + en1_edges;
        repeat (20) @(negedge CLK25MHz);
        chk("idle_quiet", en0_edges + en1_edges - k, 0);

        // abort during byte 300 with wclk high
        for (int i = 0; i < NB; i++) frame_q[i] = 8'($urandom);
        fd0 = fd_pulses;
        pulse_start();
        wait_ready(200);
        feed(0, 301, 1'b1);
        k = 0;
        while (!wclk && k < 20) begin
            @(negedge CLK25MHz);
            k++;
        end
        chk("ab_high", wclk, 1);
        e0 = en0_edges; e1 = en1_edges;
        frame_start = 1'b1;
        @(negedge CLK25MHz);
        frame_start = 1'b0;
        chk("ab_hold", wclk, 1);
        wait_ready(200);
        chk("ab_sync", en0_edges - e0, SE);
        chk("ab_noen", en1_edges - e1, 0);
        chk("ab_addr0", fe_addr, 0);
        for (int i = 0; i < 4; i++) frame_q[i] = 8'($urandom);
        feed(0, 4, 1'b1);
        wait_ready(200);
        chk("ab_new", fe_addr, 32);
        chk("ab_data", mem_mismatch(4), 0);
        chk("ab_nodone", fd_pulses, fd0);

        // asynchronous reset in the middle of a shift
        inverse_in = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        @(negedge CLK25MHz);
        byte_valid = 1'b0;
        k = 0;
        while (!wclk && k < 20) begin
            @(negedge CLK25MHz);
            k++;
        end
        chk("pre_rst", {wclk, write_en, cs, busy}, 4'hF);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_wclk", wclk, 0);
        chk("arst_we", write_en, 0);
        chk("arst_din", din, 0);
        chk("arst_cs", cs, 0);
        chk("arst_busy", {busy, byte_ready}, 0);
        inverse_in = 1'b0;
        @(negedge CLK25MHz);
        reset_n = 1'b1;
        byte_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge CLK25MHz);
            if (byte_ready || busy || wclk || write_en) bad++;
        end
        byte_valid = 1'b0;
        chk("post_idle", bad, 0);
        mon_en = 1'b1;
        inverse_in = 1'b1;
        #1;
        chk("cs_hold", cs, 0);
        @(negedge CLK25MHz);
        chk("cs_rise", cs, 1);
        inverse_in = 1'b0;
        @(negedge CLK25MHz);
        chk("cs_fall", cs, 0);

        chk("wclk_timing", tviol, 0);
        chk("done_width", fd_long, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
